// File: rtl/smash_combat_pkg.sv
// Shared combat types and constants for the per-player attack logic.
//   phase_t    : attack sequence phase (also the low two bits of the anim id)
//   atk_type_t : attack flavour latched at attack start
//   anim_id()  : packs {attack_type, phase} for the renderer
package smash_combat_pkg;

    typedef enum logic [1:0] {
        PhIdle     = 2'd0,
        PhStartup  = 2'd1,
        PhActive   = 2'd2,
        PhRecovery = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        AtkNone = 2'd0,
        AtkJab  = 2'd1,
        AtkAir  = 2'd2
    } atk_type_t;

    localparam logic [5:0] JAB_DAMAGE = 6'd6;
    localparam logic [5:0] AIR_DAMAGE = 6'd9;

    function automatic logic [3:0] anim_id(input atk_type_t t, input phase_t p);
        return {t, p};
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned bounding-box overlap test on signed coordinates.
// Ranges are half-open [lo, hi); boxes that only touch along an edge do not overlap.
//   i_a_x_lo/i_a_x_hi, i_a_y_lo/i_a_y_hi : box A extents
//   i_b_x_lo/i_b_x_hi, i_b_y_lo/i_b_y_hi : box B extents
//   o_overlap                           : 1 when the interiors intersect
module box_overlap #(
    parameter int unsigned AX_W = 12,
    parameter int unsigned AY_W = 12
) (
    input  logic signed [AX_W-1:0] i_a_x_lo,
    input  logic signed [AX_W-1:0] i_a_x_hi,
    input  logic signed [AY_W-1:0] i_a_y_lo,
    input  logic signed [AY_W-1:0] i_a_y_hi,
    input  logic signed [AX_W-1:0] i_b_x_lo,
    input  logic signed [AX_W-1:0] i_b_x_hi,
    input  logic signed [AY_W-1:0] i_b_y_lo,
    input  logic signed [AY_W-1:0] i_b_y_hi,
    output logic                   o_overlap
);

    logic w_x_hit;
    logic w_y_hit;

    assign w_x_hit   = (i_a_x_lo < i_b_x_hi) && (i_b_x_lo < i_a_x_hi);
    assign w_y_hit   = (i_a_y_lo < i_b_y_hi) && (i_b_y_lo < i_a_y_hi);
    assign o_overlap = w_x_hit && w_y_hit;

endmodule

// File: rtl/attack_hit_gen.sv
// Attacker-side hit generator: sequences one player's attack (startup/active/recovery,
// counted in video frames), tests the attack hitbox against the opponent's hurtbox
// and emits a one-clock got_hit pulse with the damage value.
// Build option: define STALE_MOVE_EN to scale damage down on repeated landed hits
// of the same attack type.
//   clk, reset (async, active low)   : clock / reset
//   frame_tick                        : one-cycle pulse per video frame
//   attack_btn                        : synchronised button level
//   grounded, facing_right, stunned   : attacker status
//   atk_x/atk_y, vic_x/vic_y          : top-left positions of attacker / victim
//   got_hit, hit_damage_out           : hit pulse and damage (damage holds between hits)
//   attack_busy, attack_anim_id       : sequence active, {attack_type, phase}
module attack_hit_gen
    import smash_combat_pkg::*;
#(
    parameter int unsigned X_W             = 10,
    parameter int unsigned Y_W             = 10,
    parameter int unsigned STARTUP_FRAMES  = 4,
    parameter int unsigned ACTIVE_FRAMES   = 3,
    parameter int unsigned RECOVERY_FRAMES = 8,
    parameter int unsigned BODY_W          = 16,
    parameter int unsigned BODY_H          = 24,
    parameter int unsigned REACH           = 24,
    parameter int unsigned HIT_H           = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           attack_btn,
    input  logic           grounded,
    input  logic           facing_right,
    input  logic           stunned,
    input  logic [X_W-1:0] atk_x,
    input  logic [Y_W-1:0] atk_y,
    input  logic [X_W-1:0] vic_x,
    input  logic [Y_W-1:0] vic_y,
    output logic           got_hit,
    output logic [5:0]     hit_damage_out,
    output logic           attack_busy,
    output logic [3:0]     attack_anim_id
);

    // Two guard bits: one for the sign (left-facing hitbox can go below 0),
    // one for headroom (right-facing hitbox can exceed 2**X_W - 1).
    localparam int unsigned XS_W = X_W + 2;
    localparam int unsigned YS_W = Y_W + 2;

    localparam logic signed [XS_W-1:0] BodyWX = XS_W'(BODY_W);
    localparam logic signed [XS_W-1:0] ReachX = XS_W'(REACH);
    localparam logic signed [YS_W-1:0] BodyHY = YS_W'(BODY_H);
    localparam logic signed [YS_W-1:0] HitHY  = YS_W'(HIT_H);

    localparam logic [3:0] StartupLast  = 4'(STARTUP_FRAMES - 1);
    localparam logic [3:0] ActiveLast   = 4'(ACTIVE_FRAMES - 1);
    localparam logic [3:0] RecoveryLast = 4'(RECOVERY_FRAMES - 1);

    phase_t    r_state, w_state_d;
    atk_type_t r_type, w_type_d;
    logic [3:0] r_cnt, w_cnt_d;
    logic       r_req, w_req_d;
    logic       r_hit_landed, w_hit_landed_d;
    logic       r_got_hit, w_got_hit_d;
    logic [5:0] r_dmg, w_dmg_d;
    logic       r_btn_q;
    logic       w_btn_edge;
    logic       w_overlap;
    logic [5:0] w_dmg_issue;

    // ---------------- hitbox / hurtbox geometry ----------------
    logic signed [XS_W-1:0] w_ax, w_vx, w_hx_lo, w_hx_hi, w_vx_hi;
    logic signed [YS_W-1:0] w_ay, w_vy, w_hy_hi, w_vy_hi;

    assign w_ax    = $signed({2'b00, atk_x});
    assign w_vx    = $signed({2'b00, vic_x});
    assign w_ay    = $signed({2'b00, atk_y});
    assign w_vy    = $signed({2'b00, vic_y});
    assign w_hx_lo = facing_right ? (w_ax + BodyWX) : (w_ax - ReachX);
    assign w_hx_hi = facing_right ? (w_ax + BodyWX + ReachX) : w_ax;
    assign w_hy_hi = w_ay + HitHY;
    assign w_vx_hi = w_vx + BodyWX;
    assign w_vy_hi = w_vy + BodyHY;

    box_overlap #(
        .AX_W (XS_W),
        .AY_W (YS_W)
    ) u_box_overlap (
        .i_a_x_lo  (w_hx_lo),
        .i_a_x_hi  (w_hx_hi),
        .i_a_y_lo  (w_ay),
        .i_a_y_hi  (w_hy_hi),
        .i_b_x_lo  (w_vx),
        .i_b_x_hi  (w_vx_hi),
        .i_b_y_lo  (w_vy),
        .i_b_y_hi  (w_vy_hi),
        .o_overlap (w_overlap)
    );

    // ---------------- damage ----------------
`ifdef STALE_MOVE_EN
    logic [1:0] r_stale, w_stale_d;
    atk_type_t  r_last_type, w_last_type_d;
    logic [5:0] w_base, w_penalty;

    assign w_base    = (r_type == AtkJab) ? JAB_DAMAGE : AIR_DAMAGE;
    // Penalty only applies when repeating the type that landed last.
    assign w_penalty = (r_type == r_last_type) ? {3'b000, r_stale, 1'b0} : 6'd0;
    assign w_dmg_issue = (w_base > w_penalty) ? (w_base - w_penalty) : 6'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stale     <= 2'd0;
            r_last_type <= AtkNone;
        end else begin
            r_stale     <= w_stale_d;
            r_last_type <= w_last_type_d;
        end
    end
`else
    assign w_dmg_issue = (r_type == AtkJab) ? JAB_DAMAGE : AIR_DAMAGE;
`endif

    // ---------------- sequencer ----------------
    assign w_btn_edge = attack_btn & ~r_btn_q;

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_req_d        = r_req;
        w_type_d       = r_type;
        w_hit_landed_d = r_hit_landed;
        w_got_hit_d    = 1'b0;
        w_dmg_d        = r_dmg;
`ifdef STALE_MOVE_EN
        w_stale_d      = r_stale;
        w_last_type_d  = r_last_type;
`endif
        if (stunned) begin
            // Stun wins over any tick or hit in the same cycle.
            w_state_d = PhIdle;
            w_cnt_d   = 4'd0;
            w_req_d   = 1'b0;
            w_type_d  = AtkNone;
        end else begin
            if ((r_state == PhIdle) && w_btn_edge) begin
                w_req_d = 1'b1;
            end
            if (frame_tick) begin
                unique case (r_state)
                    PhIdle: begin
                        if (r_req) begin
                            w_state_d      = PhStartup;
                            w_cnt_d        = 4'd0;
                            w_req_d        = 1'b0;
                            w_type_d       = grounded ? AtkJab : AtkAir;
                            w_hit_landed_d = 1'b0;
                        end
                    end
                    PhStartup: begin
                        if (r_cnt == StartupLast) begin
                            w_state_d = PhActive;
                            w_cnt_d   = 4'd0;
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end
                    PhActive: begin
                        if (w_overlap && !r_hit_landed) begin
                            w_got_hit_d    = 1'b1;
                            w_dmg_d        = w_dmg_issue;
                            w_hit_landed_d = 1'b1;
`ifdef STALE_MOVE_EN
                            if (r_type == r_last_type) begin
                                w_stale_d = (r_stale == 2'd3) ? 2'd3 : r_stale + 2'd1;
                            end else begin
                                w_stale_d     = 2'd1;
                                w_last_type_d = r_type;
                            end
`endif
                        end
                        if (r_cnt == ActiveLast) begin
                            w_state_d = PhRecovery;
                            w_cnt_d   = 4'd0;
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end
                    PhRecovery: begin
                        if (r_cnt == RecoveryLast) begin
                            w_state_d = PhIdle;
                            w_cnt_d   = 4'd0;
                            w_type_d  = AtkNone;
                        end else begin
                            w_cnt_d = r_cnt + 4'd1;
                        end
                    end
                    default: w_state_d = PhIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PhIdle;
            r_type       <= AtkNone;
            r_cnt        <= 4'd0;
            r_req        <= 1'b0;
            r_hit_landed <= 1'b0;
            r_got_hit    <= 1'b0;
            r_dmg        <= 6'd0;
            r_btn_q      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_type       <= w_type_d;
            r_cnt        <= w_cnt_d;
            r_req        <= w_req_d;
            r_hit_landed <= w_hit_landed_d;
            r_got_hit    <= w_got_hit_d;
            r_dmg        <= w_dmg_d;
            r_btn_q      <= attack_btn;
        end
    end

    assign got_hit        = r_got_hit;
    assign hit_damage_out = r_dmg;
    assign attack_busy    = (r_state != PhIdle);
    assign attack_anim_id = anim_id(r_type, r_state);

endmodule

// File: tb/tb_attack_hit_gen.sv
module tb_attack_hit_gen;

    localparam int S     = 4;
    localparam int A     = 3;
    localparam int R     = 8;
    localparam int BW    = 16;
    localparam int BH    = 24;
    localparam int REACH = 24;
    localparam int HH    = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       attack_btn = 1'b0;
    logic       grounded = 1'b1;
    logic       facing_right = 1'b1;
    logic       stunned = 1'b0;
    logic [9:0] atk_x = '0;
    logic [9:0] atk_y = '0;
    logic [9:0] vic_x = '0;
    logic [9:0] vic_y = '0;
    logic       got_hit;
    logic [5:0] hit_damage_out;
    logic       attack_busy;
    logic [3:0] attack_anim_id;

    always #5 clk = ~clk;

    attack_hit_gen dut (
        .clk            (clk),
        .reset          (reset),
        .frame_tick     (frame_tick),
        .attack_btn     (attack_btn),
        .grounded       (grounded),
        .facing_right   (facing_right),
        .stunned        (stunned),
        .atk_x          (atk_x),
        .atk_y          (atk_y),
        .vic_x          (vic_x),
        .vic_y          (vic_y),
        .got_hit        (got_hit),
        .hit_damage_out (hit_damage_out),
        .attack_busy    (attack_busy),
        .attack_anim_id (attack_anim_id)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int tag;
        bit busy;
        int anim;
        int dmg;
    } st_t;

    typedef struct {
        int tag;
        int dmg;
    } hit_t;

    st_t  sq[$];
    hit_t hq[$];

    // ---------------- reference model ----------------
    // Tracks "ticks elapsed since launch"; phase follows from that count.
    bit m_busy, m_req, m_landed, m_btn_prev;
    int m_k, m_type, m_dmg, m_stale, m_last;

    function automatic int phase_of(input int k);
        if (k < S) return 1;
        if (k < S + A) return 2;
        return 3;
    endfunction

    function automatic bit m_overlap();
        int ax, ay, vx, vy, lo, hi;
        ax = int'(atk_x);
        ay = int'(atk_y);
        vx = int'(vic_x);
        vy = int'(vic_y);
        lo = facing_right ? ax + BW : ax - REACH;
        hi = lo + REACH;
        return (lo < vx + BW) && (vx < hi) && (ay < vy + BH) && (vy < ay + HH);
    endfunction

    function automatic int m_damage();
        int d;
        d = (m_type == 1) ? 6 : 9;
`ifdef STALE_MOVE_EN
        if (m_type == m_last) begin
            d = d - 2 * m_stale;
            if (d < 1) d = 1;
            if (m_stale < 3) m_stale++;
        end else begin
            m_stale = 1;
            m_last  = m_type;
        end
`endif
        return d;
    endfunction

    task automatic model_step();
        bit   hit;
        bit   edge_seen;
        st_t  s;
        hit_t h;
        hit = 1'b0;
        if (!reset) begin
            m_busy = 0; m_req = 0; m_landed = 0; m_btn_prev = 0;
            m_k = 0; m_type = 0; m_dmg = 0; m_stale = 0; m_last = 0;
        end else begin
            edge_seen  = attack_btn && !m_btn_prev;
            m_btn_prev = attack_btn;
            if (stunned) begin
                m_busy = 0; m_req = 0; m_type = 0;
            end else if (!m_busy) begin
                if (frame_tick && m_req) begin
                    m_busy = 1; m_k = 0; m_landed = 0; m_req = 0;
                    m_type = grounded ? 1 : 2;
                end else if (edge_seen) begin
                    m_req = 1;
                end
            end else if (frame_tick) begin
                if (phase_of(m_k) == 2 && m_overlap() && !m_landed) begin
                    hit = 1'b1;
                    m_landed = 1;
                    m_dmg = m_damage();
                end
                m_k++;
                if (m_k == S + A + R) begin
                    m_busy = 0;
                    m_type = 0;
                end
            end
        end
        s.tag  = cyc + 1;
        s.busy = m_busy;
        s.anim = m_busy ? (m_type * 4 + phase_of(m_k)) : 0;
        s.dmg  = m_dmg;
        sq.push_back(s);
        if (hit) begin
            h.tag = cyc + 1;
            h.dmg = m_dmg;
            hq.push_back(h);
        end
    endtask

    // ---------------- monitor ----------------
    st_t  mon_s;
    hit_t mon_h;
    bit   mon_exp_gh;

    always @(posedge clk) begin
        #2;
        if (sq.size() > 0 && sq[0].tag == cyc) begin
            mon_s = sq.pop_front();
            check("attack_busy", 32'(attack_busy), 32'(mon_s.busy));
            check("attack_anim_id", 32'(attack_anim_id), 32'(mon_s.anim));
            check("hit_damage_hold", 32'(hit_damage_out), 32'(mon_s.dmg));
            mon_exp_gh = (hq.size() > 0) && (hq[0].tag == cyc);
            check("got_hit", 32'(got_hit), 32'(mon_exp_gh));
            if (mon_exp_gh) begin
                mon_h = hq.pop_front();
                check("hit_damage", 32'(hit_damage_out), 32'(mon_h.dmg));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: model predicts the coming posedge, then wait one cycle.
    task automatic clk_step();
        model_step();
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            clk_step();
            frame_tick = 1'b0;
            repeat (3) clk_step();
        end
    endtask

    task automatic press();
        attack_btn = 1'b1;
        clk_step();
        attack_btn = 1'b0;
        clk_step();
    endtask

    task automatic place(input int ax, input int ay, input int vx, input int vy,
                         input bit fr, input bit gr);
        atk_x = 10'(ax);
        atk_y = 10'(ay);
        vic_x = 10'(vx);
        vic_y = 10'(vy);
        facing_right = fr;
        grounded = gr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_got_hit"}, 32'(got_hit), 32'd0);
        check({tag, "_damage"}, 32'(hit_damage_out), 32'd0);
        check({tag, "_busy"}, 32'(attack_busy), 32'd0);
        check({tag, "_anim"}, 32'(attack_anim_id), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1 reset = 1'b0;
        #1 check_reset_outputs("reset_init");
        @(negedge clk);
        repeat (2) clk_step();
        reset = 1'b1;

        // Grounded jab in range.
        place(100, 200, 120, 200, 1'b1, 1'b1);
        press();
        run_ticks(18);

        // Touching edge misses, one pixel closer hits.
        place(100, 200, 140, 200, 1'b1, 1'b1);
        press();
        run_ticks(18);
        place(100, 200, 139, 200, 1'b1, 1'b1);
        press();
        run_ticks(18);

        // Air attack facing left near the stage edge (hitbox lo is negative).
        place(10, 200, 0, 200, 1'b0, 1'b0);
        press();
        run_ticks(18);

        // Stun on the first active tick with an overlapping victim.
        place(100, 200, 120, 200, 1'b1, 1'b1);
        press();
        run_ticks(1 + S);
        frame_tick = 1'b1;
        stunned = 1'b1;
        clk_step();
        frame_tick = 1'b0;
        stunned = 1'b0;
        repeat (3) clk_step();
        run_ticks(6);

        // Button edge during recovery is discarded.
        place(100, 200, 400, 200, 1'b1, 1'b1);
        press();
        run_ticks(1 + S + A + 2);
        press();
        run_ticks(R + 4);

        // Async reset mid-startup, then a normal attack.
        place(100, 200, 120, 200, 1'b1, 1'b1);
        press();
        run_ticks(3);
        reset = 1'b0;
        #1 check_reset_outputs("reset_mid");
        clk_step();
        clk_step();
        reset = 1'b1;
        press();
        run_ticks(18);

        // Repeated jabs, then air, then jab (stale scaling when built in).
        place(100, 200, 120, 200, 1'b1, 1'b1);
        repeat (3) begin
            press();
            run_ticks(17);
        end
        grounded = 1'b0;
        press();
        run_ticks(17);
        grounded = 1'b1;
        press();
        run_ticks(17);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0: atk_x = 10'($urandom_range(0, 30));
                    1: atk_x = 10'($urandom_range(990, 1023));
                    default: atk_x = 10'($urandom_range(0, 1023));
                endcase
                t = int'(atk_x) + int'($urandom_range(0, 120)) - 60;
                if (t < 0) t = 0;
                if (t > 1023) t = 1023;
                vic_x = 10'(t);
                atk_y = 10'($urandom_range(0, 1000));
                t = int'(atk_y) + int'($urandom_range(0, 60)) - 30;
                if (t < 0) t = 0;
                if (t > 1023) t = 1023;
                vic_y = 10'(t);
                facing_right = 1'($urandom_range(0, 1));
                grounded = 1'($urandom_range(0, 1));
            end
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) attack_btn = ~attack_btn;
            stunned = ($urandom_range(0, 59) == 0);
            clk_step();
        end
        frame_tick = 1'b0;
        stunned = 1'b0;
        attack_btn = 1'b0;
        repeat (4) clk_step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/attack_hit_gen.md
Name: attack_hit_gen

Overview:
- Attacker-side hit generator: runs one player's attack sequence (startup / active / recovery) in frame units.
- Tests the attack hitbox against the opponent's hurtbox.
- Issues the one-cycle got_hit pulse and the damage value that the opponent's hit-stun/damage FSM consumes.
- One instance per player; sits between input decode and the opponent's hit FSM.

Parameters:
- X_W, 10, horizontal position width (pixels, unsigned)
- Y_W, 10, vertical position width (pixels, unsigned, down-positive)
- STARTUP_FRAMES, 4, frames before the hitbox goes live (1..15)
- ACTIVE_FRAMES, 3, frames the hitbox is live (1..15)
- RECOVERY_FRAMES, 8, lockout frames after active (1..15)
- BODY_W, 16, hurtbox width
- BODY_H, 24, hurtbox height
- REACH, 24, hitbox horizontal extent beyond the body edge
- HIT_H, 16, hitbox height, top-aligned with attacker y

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- frame_tick  in  1  one-cycle pulse per video frame
- attack_btn  in  1  attack button level, already synchronised
- grounded  in  1  attacker on stage
- facing_right  in  1  attacker facing direction
- stunned  in  1  attacker is in hitstun (from its own hit FSM)
- atk_x, atk_y  in  X_W, Y_W  attacker top-left position
- vic_x, vic_y  in  X_W, Y_W  victim top-left position
- got_hit  out  1  one-clk pulse to the victim's hit FSM
- hit_damage_out  out  6  damage; valid whenever got_hit=1
- attack_busy  out  1  state != IDLE; movement logic freezes
- attack_anim_id  out  4  {attack_type[1:0], phase[1:0]}

Behaviour:
- Reset (reset=0, async): state=IDLE, frame_cnt=0, req=0, hit_landed=0, got_hit=0, hit_damage_out=0, attack_busy=0, attack_anim_id=0. Stale counter=0 when the optional feature is compiled in.
- Button edge: btn_q is registered every clk. A rising edge (attack_btn & ~btn_q) sets req only while state==IDLE. Edges in any other state are discarded, not buffered.
- FSM phases: IDLE=0, STARTUP=1, ACTIVE=2, RECOVERY=3. Transitions happen only on clk edges with frame_tick=1, except the stun abort.
- IDLE: on tick, if req and !stunned, go to STARTUP, frame_cnt=0, clear req. Latch attack_type: JAB=1 if grounded, AIR=2 otherwise.
- STARTUP, ACTIVE, RECOVERY: on tick, if frame_cnt==N-1, advance to the next phase with frame_cnt=0; else increment frame_cnt. RECOVERY wraps to IDLE.
- Full sequence is STARTUP+ACTIVE+RECOVERY ticks (15 by default).
- hit_landed is cleared on entry to STARTUP.
- Hit check: on every tick while state==ACTIVE, test AABB overlap using that cycle's positions.
  - If overlap and !hit_landed: got_hit=1 on the following cycle (exactly one clk), hit_damage_out=damage, hit_landed=1.
  - At most one hit per attack sequence.
- Damage: JAB=6, AIR=9, 6-bit unsigned.
- Hitbox x-range:
  - facing right: [atk_x+BODY_W, atk_x+BODY_W+REACH)
  - facing left: [atk_x-REACH, atk_x)
  - Computed in signed X_W+2 bits. Negative or over-width bounds are not clamped; the comparison stays correct.
- Hitbox y-range: [atk_y, atk_y+HIT_H). Hurtbox: [vic_x, vic_x+BODY_W) × [vic_y, vic_y+BODY_H).
- Overlap is strict: a_lo<b_hi && b_lo<a_hi on both axes. Touching edges do not hit.
- Stun abort: stunned=1 in any state forces IDLE on the next clk, independent of frame_tick. Clears req and frame_cnt and suppresses any hit check that cycle.
- Stun overrides a simultaneous tick/hit.
- Reset mid-attack returns to IDLE immediately. A pending got_hit is dropped.
- hit_damage_out holds its last value between pulses.

Optional Feature:
- Macro: STALE_MOVE_EN.
- Defined: a 2-bit saturating stale counter tracks consecutive landed hits of the same attack_type.
  - Same type landed: increment, saturating at 3.
  - Different type landed: reset to 1.
  - Damage issued = base − 2×stale_count (stale value before the increment), floor 1. JAB sequence: 6, 4, 2, 1.
- Undefined: counter absent; damage is always base.

Decomposition:
- Package smash_combat_pkg:
  - phase_t enum (IDLE/STARTUP/ACTIVE/RECOVERY)
  - atk_type_t enum (NONE/JAB/AIR)
  - JAB_DAMAGE, AIR_DAMAGE constants
  - anim_id composition function
- Sub-module box_overlap: combinational signed AABB comparator. Parameterised width; inputs lo/hi pairs per axis; output overlap.

Test Plan:
- Grounded jab in range: atk=(100,200), facing_right=1, vic=(120,200), edge then ticks. attack_anim_id shows phase 1 for 4 ticks, 2 for 3, 3 for 8, then IDLE after 15 ticks. Exactly one got_hit, 1 clk after the 5th tick, damage=6.
- Edge-touch miss: vic_x=140 (hitbox hi=140). No got_hit. Repeat with vic_x=139: got_hit=1.
- Air attack facing left near stage edge: atk_x=10, grounded=0, vic_x=0. got_hit with damage=9; signed bounds handle atk_x-REACH=-14.
- Stun abort: stunned pulse during ACTIVE frame 1 with victim overlapping. IDLE next clk, no got_hit. A button edge during RECOVERY is ignored.
- Async reset (reset=0) mid-STARTUP: all outputs 0 immediately. First attack after release behaves as the first scenario.
- With STALE_MOVE_EN: four consecutive landed jabs give damages 6, 4, 2, 1. An AIR hit next gives 9, then a jab gives 6.
